priority_arbiter_4ch: RTL

PRIORITY_ARBITER_4CH -- requirements
Module: priority_arbiter_4ch

---
 rtl/priority_arbiter_4ch.sv | 129 ++++++++++++
 1 files changed

// File: rtl/priority_arbiter_4ch.sv
// ============================================================================
// priority_arbiter_4ch : 4-requester arbiter, fixed or round-robin priority,
//                        bounded hold time with forced release. Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module priority_arbiter_4ch #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       rr_mode,
    output logic [3:0] grant,
    output logic [1:0] grant_id,
    output logic       grant_valid,
    output logic       timeout_pulse
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    state_t     state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] id_q, id_d;
    logic [1:0] last_q, last_d;
    logic       valid_q, valid_d;
    logic       to_q, to_d;
    logic [7:0] hold_q, hold_d;

    logic [1:0] fix_id;
    logic [1:0] rr_id;
    logic [1:0] win_id;

    // Later iterations overwrite earlier ones, so the highest set bit wins for
    // fixed mode and the nearest bit after last_q wins for round-robin.
    always_comb begin
        fix_id = 2'd0;
        rr_id  = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (req[i]) fix_id = 2'(i);
        end
        for (int k = 4; k >= 1; k--) begin
            if (req[last_q + 2'(k)]) rr_id = last_q + 2'(k);
        end
        win_id = rr_mode ? rr_id : fix_id;
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        id_d    = id_q;
        valid_d = valid_q;
        to_d    = 1'b0;
        hold_d  = hold_q;
        last_d  = last_q;
        case (state_q)
            IDLE, GAP: begin
                if (|req) begin
                    state_d = BUSY;
                    grant_d = 4'b0001 << win_id;
                    id_d    = win_id;
                    valid_d = 1'b1;
                    hold_d  = 8'd1;
                    last_d  = win_id;
                end else begin
                    state_d = IDLE;
                    grant_d = 4'b0000;
                    id_d    = 2'd0;
                    valid_d = 1'b0;
                    hold_d  = 8'd0;
                end
            end
            BUSY: begin
                if (!req[id_q] || (hold_q >= HOLD_LIMIT)) begin
                    state_d = GAP;
                    grant_d = 4'b0000;
                    id_d    = 2'd0;
                    valid_d = 1'b0;
                    hold_d  = 8'd0;
                    to_d    = req[id_q];
                end else begin
                    hold_d  = hold_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
                id_d    = 2'd0;
                valid_d = 1'b0;
                hold_d  = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= 4'b0000;
            id_q    <= 2'd0;
            last_q  <= 2'd3;
            valid_q <= 1'b0;
            to_q    <= 1'b0;
            hold_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            to_q    <= to_d;
            hold_q  <= hold_d;
        end
    end

    assign grant         = grant_q;
    assign grant_id      = id_q;
    assign grant_valid   = valid_q;
    assign timeout_pulse = to_q;

endmodule

`default_nettype wire
